vga_pixel_fetch: RTL
====================

# vga_pixel_fetch

Fetch stage directly upstream of the grayscale image display stage in the VGA path. Takes the pixel coordinates from the VGA timing generator, walks a packed 8-bit grayscale image held in data ROM (4 pixels per 32-bit word), and issues word reads. Presents each pixel byte in bits [7:0] of a 32-bit data word, together with the coordinates delayed to match, so the display stage receives aligned `x`/`y`/data. Also owns the start handshake and frame bookkeeping for the image.

## Interface
- `IMG_W`, 400, image width in pixels; multiple of 4
- `IMG_H`, 400, image height in pixels
- `ADDR_W`, 16, ROM word-address width; covers IMG_W*IMG_H/4 words
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `pix_en`  in  1  pixel tick from the timing generator; all stage advances happen only on cycles with `pix_en`=1
- `x_in`  in  10  current horizontal coordinate
- `y_in`  in  10  current vertical coordinate
- `start`  in  1  one-cycle request to begin displaying the image
- `rom_addr`  out  ADDR_W  data-ROM word address
- `rom_rd`  out  1  read strobe, one clk wide
- `rom_data`  in  32  ROM read data; valid exactly 1 clk after `rom_rd`
- `x_out`  out  10  `x_in` delayed to align with `data_out`
- `y_out`  out  10  `y_in` delayed to align with `data_out`
- `data_out`  out  32  pixel word for the display stage: pixel in [7:0], [31:8] always zero
- `busy`  out  1  high in ARMED and RUN
- `frame_done`  out  1  one-clk pulse when the last image pixel is presented

## Operation
- FSM states: IDLE, ARMED, RUN.
  - IDLE -> ARMED on `start`=1.
  - ARMED -> RUN on a `pix_en` cycle with `x_in`=0 and `y_in`=0.
  - RUN stays in RUN across frames until reset. `start` in ARMED or RUN is ignored.
- In range: `x_in` < IMG_W and `y_in` < IMG_H.
- Pixel index counter `idx` (18 bits):
  - Cleared on the `pix_en` cycle with `x_in`=0 and `y_in`=0.
  - Incremented by 1 on each `pix_en` cycle that is in range in RUN.
  - There is no multiplier; the address comes from `idx` only.
- Word address = `idx`[17:2]. Byte select = `idx`[1:0]. Byte 0 is in `rom_data`[7:0]; byte 3 is in [31:24].
- Read issue:
  - In RUN, on an in-range `pix_en` cycle with byte select 0, the block drives `rom_addr` = `idx`[17:2] and pulses `rom_rd`.
  - The returned word is latched into a word buffer on the following clk.
  - Byte selects 1–3 use the buffered word; no read is issued for them.
  - Rows always start word-aligned because IMG_W is a multiple of 4.
- Output formation:
  - The selected byte is zero-extended into `data_out`.
  - `data_out` = 0 when the delayed coordinate is out of range, or when the FSM was not in RUN at capture.
- `frame_done` pulses on the clk where `data_out` carries the pixel at (IMG_W-1, IMG_H-1).

## Timing
- Reset (sampled on `clk` with `reset`=0): state IDLE, `idx` 0, word buffer 0, `rom_addr` 0, `rom_rd` 0, `x_out` 0, `y_out` 0, `data_out` 0, `busy` 0, `frame_done` 0, pipeline valid bits cleared.
- Reset mid-frame takes effect on that same edge. The next frame starts only after a new `start` followed by (0,0).
- Latency is 2 `pix_en` ticks.
  - Coordinates captured on tick n appear on `x_out`/`y_out`/`data_out` after tick n+2.
  - Outputs are registered and change only on `pix_en` cycles.
- The ROM latency (1 clk) must be no longer than the `pix_en` spacing. Consecutive `pix_en` cycles (spacing 1) are legal: the word is latched before the next tick uses it.
- `rom_rd` is never asserted outside RUN, out of range, or when `pix_en`=0.
- `start` and (0,0) in the same cycle while IDLE: the block goes to ARMED only. RUN begins at the next (0,0), one frame later.

## Test plan
- Reset low 3 clks with `pix_en` toggling -> all outputs 0, `rom_rd` never asserted, `busy`=0.
- `start` pulse, then sweep a 640x480 raster with ROM word k = {4{k[7:0]}} -> first read at (0,0) with addr 0; `data_out`=0x00000000 for (0,0); at (4,0) addr 1 and `data_out`=0x00000001; output is 2 ticks behind input.
- ROM word 0 = 0x44332211 -> `data_out` at (0..3,0) is 0x11, 0x22, 0x33, 0x44; exactly one `rom_rd` for those four pixels.
- Pixels x≥400 or y≥400 -> `data_out`=0, no `rom_rd`; word address at (0,1) = 100; at (399,399) = 39999; `frame_done` pulses once with `x_out`=399, `y_out`=399.
- Reset asserted at (200,150) mid-frame -> outputs 0 next clk; without a new `start`, no reads occur through a full frame.
- `pix_en` every clk versus every 2nd clk -> identical `data_out` sequence per tick.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// Walks a packed 8-bit grayscale image (4 pixels per ROM word) in step with the
// VGA raster; each pixel leaves with its coordinates two pix_en ticks after capture.
module vga_pixel_fetch #(
  parameter int IMG_W  = 400,
  parameter int IMG_H  = 400,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [9:0]        x_in,
  input  logic [9:0]        y_in,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [31:0]       rom_data,
  output logic [9:0]        x_out,
  output logic [9:0]        y_out,
  output logic [31:0]       data_out,
  output logic              busy,
  output logic              frame_done
);
  localparam int         IDX_W  = ADDR_W + 2;
  localparam logic [9:0] W_LIM  = 10'(IMG_W);
  localparam logic [9:0] H_LIM  = 10'(IMG_H);
  localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        word_q, word_d;
  logic               rd_pend_q, rd_pend_d;
  logic [9:0]         x1_q, x1_d, y1_q, y1_d;
  logic               v1_q, v1_d;
  logic [1:0]         sel1_q, sel1_d;
  logic [9:0]         x2_q, x2_d, y2_q, y2_d;
  logic               v2_q, v2_d;
  logic [7:0]         pix2_q, pix2_d;
  logic [9:0]         x_out_q, x_out_d, y_out_q, y_out_d;
  logic [31:0]        data_out_q, data_out_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  logic               at_origin, in_range, run_now, fetch;
  logic [IDX_W-1:0]   idx_cur;
  logic [31:0]        word_now;
  logic [7:0]         pix_sel;

  always_comb begin
    at_origin = pix_en && (x_in == 10'd0) && (y_in == 10'd0);
    in_range  = (x_in < W_LIM) && (y_in < H_LIM);
    // The (0,0) tick that leaves ARMED already belongs to the running frame.
    run_now   = (state_q == RUN) || ((state_q == ARMED) && at_origin);
    idx_cur   = at_origin ? '0 : idx_q;
    fetch     = reset && pix_en && run_now && in_range;
    rom_rd    = fetch && (idx_cur[1:0] == 2'd0);
    rom_addr  = rom_rd ? idx_cur[IDX_W-1:2] : '0;

    // With back-to-back ticks the fresh word is still on rom_data, not yet buffered.
    word_now = rd_pend_q ? rom_data : word_q;
    case (sel1_q)
      2'd0:    pix_sel = word_now[7:0];
      2'd1:    pix_sel = word_now[15:8];
      2'd2:    pix_sel = word_now[23:16];
      default: pix_sel = word_now[31:24];
    endcase

    state_d      = state_q;
    idx_d        = idx_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    v1_d         = v1_q;
    sel1_d       = sel1_q;
    x2_d         = x2_q;
    y2_d         = y2_q;
    v2_d         = v2_q;
    pix2_d       = pix2_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    data_out_d   = data_out_q;
    frame_done_d = 1'b0;
    rd_pend_d    = rom_rd;
    word_d       = rd_pend_q ? rom_data : word_q;

    case (state_q)
      IDLE:    if (start) state_d = ARMED;
      ARMED:   if (at_origin) state_d = RUN;
      default: state_d = state_q;
    endcase
    busy_d = (state_d != IDLE);

    if (pix_en) begin
      idx_d        = fetch ? idx_cur + 1'b1 : idx_cur;
      x1_d         = x_in;
      y1_d         = y_in;
      v1_d         = fetch;
      sel1_d       = idx_cur[1:0];
      x2_d         = x1_q;
      y2_d         = y1_q;
      v2_d         = v1_q;
      pix2_d       = v1_q ? pix_sel : 8'd0;
      x_out_d      = x2_q;
      y_out_d      = y2_q;
      data_out_d   = {24'd0, pix2_q};
      frame_done_d = v2_q && (x2_q == X_LAST) && (y2_q == Y_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      word_q       <= '0;
      rd_pend_q    <= 1'b0;
      x1_q         <= '0;
      y1_q         <= '0;
      v1_q         <= 1'b0;
      sel1_q       <= '0;
      x2_q         <= '0;
      y2_q         <= '0;
      v2_q         <= 1'b0;
      pix2_q       <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      data_out_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      rd_pend_q    <= rd_pend_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      v1_q         <= v1_d;
      sel1_q       <= sel1_d;
      x2_q         <= x2_d;
      y2_q         <= y2_d;
      v2_q         <= v2_d;
      pix2_q       <= pix2_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      data_out_q   <= data_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign data_out   = data_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
endmodule
